divide_fixed_pipe: RTL and testbench
====================================

Name: divide_fixed_pipe

Overview:
- Parametrised signed fixed-point divider for the FM radio datapath.
- Reads one dividend from FIFO A and one divisor from FIFO B, and computes the quotient as (A << FRAC_BITS) / B, truncated toward zero.
- Uses a radix-2 restoring iteration, one quotient bit per clock.
- Saturates on overflow and on divide-by-zero, flags saturation on the output, and writes the result to an output FIFO.

Parameters:
- WIDTH, 32: bit width of dividend, divisor and quotient (two's complement).
- FRAC_BITS, 10: fractional bits of the Q-format. 0 gives plain integer division.
- ITERS, WIDTH+FRAC_BITS+1: derived, not to be overridden. Number of restoring steps.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- inA_rd_en  out  1  pop dividend FIFO
- inA_empty  in  1  dividend FIFO empty
- inA_dout  in  WIDTH  signed dividend
- inB_rd_en  out  1  pop divisor FIFO
- inB_empty  in  1  divisor FIFO empty
- inB_dout  in  WIDTH  signed divisor
- out_wr_en  out  1  push quotient
- out_full  in  1  output FIFO full
- out_din  out  WIDTH  signed quotient
- out_sat  out  1  quotient was saturated (overflow or divide-by-zero); valid with out_wr_en

Behaviour:
- Reset state: all outputs 0, state S_IDLE, internal registers 0.
- Reset asserted mid-operation aborts the operation. The operand pair already popped is discarded and no write occurs.
- FIFO handshake:
  - rd_en and wr_en are combinational from the current state and FIFO flags.
  - inA_rd_en and inB_rd_en always assert together, only when both FIFOs are non-empty. A single non-empty FIFO is never popped.
  - out_wr_en asserts only when !out_full.
- States:
  - S_IDLE: if !inA_empty && !inB_empty, assert both rd_en and latch the operands. Then:
    - divisor == 0 → go to S_FIX with div0 = 1.
    - otherwise → go to S_ITER with count = 0.
  - S_ITER: one restoring step per cycle. Go to S_FIX when count == ITERS-1.
  - S_FIX: apply sign and saturation, register out_din and out_sat. Go to S_OUT.
  - S_OUT: hold the result until !out_full, then assert out_wr_en for exactly one cycle and go to S_IDLE. out_din and out_sat are driven only while out_wr_en = 1, and are 0 otherwise.
- Latency: with pop in cycle t, the earliest write is in cycle t+ITERS+2. For divide-by-zero it is t+2.
- Throughput: one result per ITERS+3 cycles. No overlap between operations. The next pop can occur in the cycle after the write.
- Arithmetic:
  - Magnitudes are held in WIDTH+1 bits, so |−2^(WIDTH−1)| is representable.
  - The numerator magnitude |A| << FRAC_BITS is ITERS bits wide. The partial remainder is WIDTH+2 bits.
  - Result sign = signA XOR signB. The quotient magnitude is computed unsigned and then negated if the sign is negative.
  - Positive result: magnitude > 2^(WIDTH−1)−1 → out_din = max positive, out_sat = 1.
  - Negative result: magnitude > 2^(WIDTH−1) → out_din = min negative, out_sat = 1.
  - Divide-by-zero: A >= 0 → max positive; A < 0 → min negative; out_sat = 1.
  - A zero quotient with a negative sign outputs 0, never −0 artefacts.
- The remainder is computed internally but not output.

Decomposition:
- div_pkg: state enum (S_IDLE, S_ITER, S_FIX, S_OUT), and functions for max/min saturation constants as a function of WIDTH.
- Sub-module div_restore_step, purely combinational:
  - Inputs: partial remainder, next numerator bit, divisor magnitude.
  - Outputs: new remainder and quotient bit.
  - Instanced once inside the FSM datapath.

Test Plan:
- WIDTH=32, FRAC_BITS=0, A=100, B=7 → one write, out_din=14, out_sat=0, exactly ITERS+2 cycles after the pop. Also A=−100, B=7 → −14, and A=−100, B=−7 → 14.
- FRAC_BITS=10, A=1024 (1.0), B=2048 → out_din=512 (0.5). Also A=−3072, B=1024 → −3072 (−3.0).
- FRAC_BITS=0, A=−2^31, B=−1 → out_din=0x7FFFFFFF, out_sat=1. Also A=−2^31, B=1 → 0x80000000, out_sat=0.
- B=0 with A=5 → 0x7FFFFFFF, out_sat=1; with A=−5 → 0x80000000, out_sat=1. Both written 2 cycles after the pop.
- inA non-empty with inB_empty held 10 cycles → no rd_en. When B arrives, both pop in the same cycle. Then out_full held high for 5 cycles at S_OUT → no write and result stable; a single write on the cycle out_full drops.
- Reset asserted mid-S_ITER → outputs 0 and state S_IDLE asynchronously. After release, the next operand pair is processed correctly and no stale write occurs.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the fixed-point restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    // Wide enough for any practical WIDTH; callers truncate to their own width.
    localparam int SAT_W = 64;

    function automatic logic [SAT_W-1:0] sat_max(input int width);
        return (SAT_W'(1) << (width - 1)) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int width);
        return SAT_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift in a numerator bit, trial-subtract the divisor.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] rem_i,
    input  logic             num_bit_i,
    input  logic [WIDTH:0]   dmag_i,
    output logic [WIDTH+1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH+2:0] trial;
    logic [WIDTH+2:0] dext;

    assign trial   = {rem_i, num_bit_i};
    assign dext    = (WIDTH+3)'(dmag_i);
    assign q_bit_o = (trial >= dext);
    // The remainder stays below the divisor magnitude, so dropping the top bit is lossless.
    assign rem_o   = q_bit_o ? (WIDTH+2)'(trial - dext) : (WIDTH+2)'(trial);

endmodule

// File: rtl/divide_fixed_pipe.sv
// Signed fixed-point divider: quotient = (A << FRAC_BITS) / B, truncated toward zero,
// one quotient bit per clock, saturating on overflow and divide-by-zero.
//
// state  | meaning
// S_IDLE | wait for both operand FIFOs non-empty, pop and latch operands
// S_ITER | one restoring step per cycle, ITERS cycles
// S_FIX  | apply sign and saturation, register result
// S_OUT  | hold result until output FIFO has room, write once
module divide_fixed_pipe
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 10
) (
    input  logic             clock,
    input  logic             reset,
    output logic             inA_rd_en,
    input  logic             inA_empty,
    input  logic [WIDTH-1:0] inA_dout,
    output logic             inB_rd_en,
    input  logic             inB_empty,
    input  logic [WIDTH-1:0] inB_dout,
    output logic             out_wr_en,
    input  logic             out_full,
    output logic [WIDTH-1:0] out_din,
    output logic             out_sat
);

    localparam int ITERS = WIDTH + FRAC_BITS + 1;
    localparam int CW    = $clog2(ITERS);

    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(sat_min(WIDTH));
    localparam logic [ITERS-1:0] POS_LIM = ITERS'(MAX_POS);
    localparam logic [ITERS-1:0] NEG_LIM = ITERS'(MIN_NEG);

    state_e            state_q;
    logic [CW-1:0]     count_q;
    logic [ITERS-1:0]  num_q;
    logic [ITERS-1:0]  quo_q;
    logic [WIDTH:0]    dmag_q;
    logic [WIDTH+1:0]  rem_q;
    logic              neg_q;
    logic              div0_q;
    logic [WIDTH-1:0]  res_q;
    logic              sat_q;

    logic [WIDTH+1:0]  rem_d;
    logic              qbit_d;
    logic              pop;
    logic [WIDTH:0]    a_ext;
    logic [WIDTH:0]    b_ext;
    logic [WIDTH:0]    a_mag_d;
    logic [WIDTH:0]    b_mag_d;
    logic              b_zero;

    // One extra bit so the magnitude of the most negative value is representable.
    assign a_ext   = {inA_dout[WIDTH-1], inA_dout};
    assign b_ext   = {inB_dout[WIDTH-1], inB_dout};
    assign a_mag_d = a_ext[WIDTH] ? -a_ext : a_ext;
    assign b_mag_d = b_ext[WIDTH] ? -b_ext : b_ext;
    assign b_zero  = (inB_dout == '0);

    assign pop       = !reset && (state_q == S_IDLE) && !inA_empty && !inB_empty;
    assign inA_rd_en = pop;
    assign inB_rd_en = pop;
    assign out_wr_en = (state_q == S_OUT) && !out_full;
    assign out_din   = out_wr_en ? res_q : '0;
    assign out_sat   = out_wr_en & sat_q;

    div_restore_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .num_bit_i(num_q[ITERS-1]),
        .dmag_i   (dmag_q),
        .rem_o    (rem_d),
        .q_bit_o  (qbit_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            num_q   <= '0;
            quo_q   <= '0;
            dmag_q  <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            res_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        num_q   <= ITERS'(a_mag_d) << FRAC_BITS;
                        dmag_q  <= b_mag_d;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        count_q <= '0;
                        // With B == 0 the sign reduces to the sign of A, which picks the rail.
                        neg_q   <= inA_dout[WIDTH-1] ^ inB_dout[WIDTH-1];
                        div0_q  <= b_zero;
                        state_q <= b_zero ? S_FIX : S_ITER;
                    end
                end
                S_ITER: begin
                    rem_q   <= rem_d;
                    quo_q   <= {quo_q[ITERS-2:0], qbit_d};
                    num_q   <= num_q << 1;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(ITERS - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (div0_q) begin
                        res_q <= neg_q ? MIN_NEG : MAX_POS;
                        sat_q <= 1'b1;
                    end else if (neg_q) begin
                        if (quo_q > NEG_LIM) begin
                            res_q <= MIN_NEG;
                            sat_q <= 1'b1;
                        end else begin
                            res_q <= -quo_q[WIDTH-1:0];
                            sat_q <= 1'b0;
                        end
                    end else begin
                        if (quo_q > POS_LIM) begin
                            res_q <= MAX_POS;
                            sat_q <= 1'b1;
                        end else begin
                            res_q <= quo_q[WIDTH-1:0];
                            sat_q <= 1'b0;
                        end
                    end
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    if (!out_full) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_fixed_pipe.sv
// Bench for divide_fixed_pipe: integer (FRAC_BITS=0) and Q10 instances with a scoreboard per instance.
module tb_divide_fixed_pipe;

    localparam int IT0 = 33;
    localparam int IT1 = 43;

    typedef struct {
        logic [31:0] din;
        logic        sat;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        a0_rd, b0_rd, a0_empty, b0_empty, o0_wr, o0_full, o0_sat;
    logic [31:0] a0_dout, b0_dout, o0_din;
    logic        a1_rd, b1_rd, a1_empty, b1_empty, o1_wr, o1_full, o1_sat;
    logic [31:0] a1_dout, b1_dout, o1_din;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   nolat0 = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    divide_fixed_pipe #(.WIDTH(32), .FRAC_BITS(0)) u0 (
        .clock(clock), .reset(reset),
        .inA_rd_en(a0_rd), .inA_empty(a0_empty), .inA_dout(a0_dout),
        .inB_rd_en(b0_rd), .inB_empty(b0_empty), .inB_dout(b0_dout),
        .out_wr_en(o0_wr), .out_full(o0_full), .out_din(o0_din), .out_sat(o0_sat)
    );

    divide_fixed_pipe #(.WIDTH(32), .FRAC_BITS(10)) u1 (
        .clock(clock), .reset(reset),
        .inA_rd_en(a1_rd), .inA_empty(a1_empty), .inA_dout(a1_dout),
        .inB_rd_en(b1_rd), .inB_empty(b1_empty), .inB_dout(b1_dout),
        .out_wr_en(o1_wr), .out_full(o1_full), .out_din(o1_din), .out_sat(o1_sat)
    );

    // Reference: exact signed integer division on 64 bits, then clamp.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int frac,
                                   input int pop, input int iters, input bit nolat);
        exp_t   e;
        longint num;
        longint q;
        num = longint'($signed(a)) * (longint'(1) << frac);
        if (b == 32'd0) begin
            e.din = ($signed(a) < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            e.sat = 1'b1;
            e.due = pop + 2;
        end else begin
            q = num / longint'($signed(b));
            e.due = pop + iters + 2;
            if (q > 64'sd2147483647) begin
                e.din = 32'h7FFF_FFFF;
                e.sat = 1'b1;
            end else if (q < -64'sd2147483648) begin
                e.din = 32'h8000_0000;
                e.sat = 1'b1;
            end else begin
                e.din = 32'(q);
                e.sat = 1'b0;
            end
        end
        if (nolat) e.due = -1;
        return e;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        total++;
        assert ((a0_rd === b0_rd) && (!a0_rd || (!a0_empty && !b0_empty)) && (!o0_wr || !o0_full)
                && (o0_wr || (o0_din === 32'd0 && o0_sat === 1'b0)))
        else begin
            bad++;
            $error("FAIL hs0: rdA=%b rdB=%b wr=%b din=%h sat=%b required consistent handshake, zero idle outputs",
                   a0_rd, b0_rd, o0_wr, o0_din, o0_sat);
        end
        if (a0_rd === 1'b1) q0.push_back(model(a0_dout, b0_dout, 0, cyc, IT0, nolat0));
        if (o0_wr === 1'b1) begin
            total++;
            assert (q0.size() > 0)
            else begin
                bad++;
                $error("FAIL spurious0: write din=%h with no expected result", o0_din);
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                total++;
                assert ({o0_din, o0_sat} === {e.din, e.sat})
                else begin
                    bad++;
                    $error("FAIL data0: got din=%h sat=%b want din=%h sat=%b", o0_din, o0_sat, e.din, e.sat);
                end
                if (e.due >= 0) begin
                    total++;
                    assert (cyc === e.due)
                    else begin
                        bad++;
                        $error("FAIL lat0: write cycle %0d want %0d", cyc, e.due);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        total++;
        assert ((a1_rd === b1_rd) && (!a1_rd || (!a1_empty && !b1_empty)) && (!o1_wr || !o1_full)
                && (o1_wr || (o1_din === 32'd0 && o1_sat === 1'b0)))
        else begin
            bad++;
            $error("FAIL hs1: rdA=%b rdB=%b wr=%b din=%h sat=%b required consistent handshake, zero idle outputs",
                   a1_rd, b1_rd, o1_wr, o1_din, o1_sat);
        end
        if (a1_rd === 1'b1) q1.push_back(model(a1_dout, b1_dout, 10, cyc, IT1, 1'b0));
        if (o1_wr === 1'b1) begin
            total++;
            assert (q1.size() > 0)
            else begin
                bad++;
                $error("FAIL spurious1: write din=%h with no expected result", o1_din);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                total++;
                assert ({o1_din, o1_sat} === {e.din, e.sat})
                else begin
                    bad++;
                    $error("FAIL data1: got din=%h sat=%b want din=%h sat=%b", o1_din, o1_sat, e.din, e.sat);
                end
                total++;
                assert (cyc === e.due)
                else begin
                    bad++;
                    $error("FAIL lat1: write cycle %0d want %0d", cyc, e.due);
                end
            end
        end
    end

    task automatic issue(input int inst, input logic [31:0] a, input logic [31:0] b);
        bit got;
        got = 1'b0;
        @(posedge clock); #1;
        if (inst == 0) begin
            a0_dout = a; b0_dout = b; a0_empty = 1'b0; b0_empty = 1'b0;
        end else begin
            a1_dout = a; b1_dout = b; a1_empty = 1'b0; b1_empty = 1'b0;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if ((inst == 0 && a0_rd === 1'b1) || (inst == 1 && a1_rd === 1'b1)) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        assert (got)
        else begin
            bad++;
            $error("FAIL pop%0d: no pop seen, got 0 want 1", inst);
        end
        @(posedge clock); #1;
        if (inst == 0) begin
            a0_empty = 1'b1; b0_empty = 1'b1;
        end else begin
            a1_empty = 1'b1; b1_empty = 1'b1;
        end
    endtask

    task automatic wait_done(input int inst);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
                done = 1'b1;
                break;
            end
        end
        total++;
        assert (done)
        else begin
            bad++;
            $error("FAIL drain%0d: results still pending, got 0 want 1", inst);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a0_empty = 1'b1; b0_empty = 1'b1; a0_dout = '0; b0_dout = '0; o0_full = 1'b0;
        a1_empty = 1'b1; b1_empty = 1'b1; a1_dout = '0; b1_dout = '0; o1_full = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        assert ({o0_wr, o0_din, o0_sat, a0_rd, b0_rd, o1_wr, o1_din, o1_sat, a1_rd, b1_rd} === '0)
        else begin
            bad++;
            $error("FAIL reset_state: outputs got nonzero want all 0");
        end
        @(posedge clock); #3;
        reset = 1'b0;

        // Integer division, signs, extremes and divide-by-zero.
        issue(0, 32'd100, 32'd7);
        issue(0, -32'sd100, 32'd7);
        issue(0, -32'sd100, -32'sd7);
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(0, 32'h8000_0000, 32'd1);
        issue(0, 32'd5, 32'd0);
        issue(0, -32'sd5, 32'd0);
        issue(0, 32'd3, -32'sd7);
        wait_done(0);

        // Q10 fractional results, truncation toward zero and overflow.
        issue(1, 32'd1024, 32'd2048);
        issue(1, -32'sd3072, 32'd1024);
        issue(1, 32'd3, 32'd7);
        issue(1, -32'sd3, 32'd7);
        issue(1, 32'h4000_0000, 32'd1);
        issue(1, 32'h8000_0000, -32'sd1024);
        issue(1, 32'd0, -32'sd5);
        issue(1, -32'sd9, 32'd0);
        wait_done(1);

        // Only A present: no pop; then both pop together; output back-pressure.
        @(posedge clock); #1;
        a0_dout = 32'd1000; a0_empty = 1'b0; b0_dout = -32'sd3; b0_empty = 1'b1;
        o0_full = 1'b1; nolat0 = 1'b1;
        repeat (10) begin
            @(negedge clock);
            total++;
            assert (a0_rd === 1'b0 && b0_rd === 1'b0)
            else begin
                bad++;
                $error("FAIL lone_a: rd got %b/%b want 0/0", a0_rd, b0_rd);
            end
        end
        @(posedge clock); #1;
        b0_empty = 1'b0;
        @(negedge clock);
        total++;
        assert (a0_rd === 1'b1 && b0_rd === 1'b1)
        else begin
            bad++;
            $error("FAIL pair_pop: rd got %b/%b want 1/1", a0_rd, b0_rd);
        end
        @(posedge clock); #1;
        a0_empty = 1'b1; b0_empty = 1'b1; nolat0 = 1'b0;
        repeat (34) @(negedge clock);
        repeat (5) begin
            @(negedge clock);
            total++;
            assert (o0_wr === 1'b0 && o0_din === 32'd0)
            else begin
                bad++;
                $error("FAIL full_hold: wr=%b din=%h want 0/0", o0_wr, o0_din);
            end
        end
        @(posedge clock); #1;
        o0_full = 1'b0;
        @(negedge clock);
        total++;
        assert (o0_wr === 1'b1)
        else begin
            bad++;
            $error("FAIL full_drop: wr got %b want 1", o0_wr);
        end
        @(negedge clock);
        total++;
        assert (o0_wr === 1'b0)
        else begin
            bad++;
            $error("FAIL single_write: wr got %b want 0", o0_wr);
        end
        wait_done(0);

        // Reset in the middle of an iteration discards the operation.
        issue(0, 32'd123456, -32'sd9);
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b1;
        q0.delete();
        a0_dout = 32'd77; b0_dout = 32'd5; a0_empty = 1'b0; b0_empty = 1'b0;
        #1;
        total++;
        assert (o0_wr === 1'b0 && o0_din === 32'd0 && o0_sat === 1'b0 && a0_rd === 1'b0 && b0_rd === 1'b0)
        else begin
            bad++;
            $error("FAIL async_reset: wr=%b din=%h sat=%b rd=%b want all 0", o0_wr, o0_din, o0_sat, a0_rd);
        end
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b0;
        @(negedge clock);
        total++;
        assert (a0_rd === 1'b1 && b0_rd === 1'b1)
        else begin
            bad++;
            $error("FAIL post_reset_pop: rd got %b/%b want 1/1", a0_rd, b0_rd);
        end
        @(posedge clock); #1;
        a0_empty = 1'b1; b0_empty = 1'b1;
        wait_done(0);
        repeat (5) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
